// File: rtl/mac_seq_ctrl.sv
// Address/control sequencer for a matrix-vector product on a single MAC:
// streams row-major matrix and vector addresses, then hands each row's dot product to a consumer.
module mac_seq_ctrl #(
  parameter int RW = 8,
  parameter int CW = 8,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [RW-1:0] num_rows,
  input  logic [CW-1:0] num_cols,
  output logic          ready,
  output logic [AW-1:0] addr_w,
  output logic [CW-1:0] addr_x,
  output logic          valid_input,
  output logic          clear_acc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] row_idx,
  output logic          done
);

  // Result handshake: a row result transfers on a rising clk edge where out_valid && out_ready;
  // out_valid and row_idx hold steady until then, and out_ready is ignored while out_valid=0.

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] m_q, m_d;
  logic [CW-1:0] n_q, n_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          drain_q, drain_d;
  logic          vin_q;
  logic          done_q, done_d;
  logic          clear_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      n_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      drain_q <= 1'b0;
      vin_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      vin_q   <= (state_q == S_ISSUE);
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    n_d       = n_q;
    row_d     = row_q;
    col_d     = col_q;
    addr_d    = addr_q;
    drain_d   = drain_q;
    done_d    = 1'b0;
    clear_c   = 1'b0;
    ready     = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          if (num_rows != '0 && num_cols != '0) begin
            m_d     = num_rows;
            n_d     = num_cols;
            row_d   = '0;
            col_d   = '0;
            addr_d  = '0;
            clear_c = 1'b1;
            state_d = S_ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (col_q == n_q - 1'b1) begin
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          col_d  = col_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // Two cycles: one for the memory read, one for the MAC product/accumulate stage.
        if (drain_q) state_d = S_OUT;
        else         drain_d = 1'b1;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          clear_c = 1'b1;
          if (row_q == m_q - 1'b1) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            // The address counter simply continues: (row+1)*N is one past row*N+N-1.
            row_d   = row_q + 1'b1;
            col_d   = '0;
            addr_d  = addr_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign clear_acc   = clear_c & ~reset;
  assign addr_w      = addr_q;
  assign addr_x      = col_q;
  assign valid_input = vin_q;
  assign row_idx     = row_q;
  assign done        = done_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: models the memories and MAC, and scores every row result and done
// pulse against dot products computed directly from the matrix and vector contents.
module tb_mac_seq_ctrl;
  localparam int RW = 8;
  localparam int CW = 8;
  localparam int AW = 16;
  localparam int EW = 41;  // {is_done, row[7:0], value[31:0]}

  logic          clk;
  logic          reset;
  logic          start;
  logic [RW-1:0] num_rows;
  logic [CW-1:0] num_cols;
  logic          ready;
  logic [AW-1:0] addr_w;
  logic [CW-1:0] addr_x;
  logic          valid_input;
  logic          clear_acc;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] row_idx;
  logic          done;

  mac_seq_ctrl #(.RW(RW), .CW(CW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows), .num_cols(num_cols),
    .ready(ready), .addr_w(addr_w), .addr_x(addr_x), .valid_input(valid_input),
    .clear_acc(clear_acc), .out_valid(out_valid), .out_ready(out_ready),
    .row_idx(row_idx), .done(done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0]    wmem [256];
  logic [7:0]    xmem [256];
  logic [EW-1:0] exp_q [$];
  logic [AW-1:0] aw_log [$];
  logic [CW-1:0] ax_log [$];
  int            compared;
  int            mismatched;
  int            cur_n;
  int            or_mode;  // 0: always ready, 1: random, 2: held low

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // scoreboard monitor: memory model with 1-cycle read latency feeding an accumulator
  logic [31:0]   acc;
  logic [AW-1:0] prev_aw;
  logic [CW-1:0] prev_ax;
  logic [RW-1:0] prev_row;
  logic [EW-1:0] e;

  always @(negedge clk) begin
    if (reset) begin
      acc = '0;
      prev_aw = '0;
      prev_ax = '0;
      prev_row = '0;
    end else begin
      check("clear_vs_valid_input", {63'd0, clear_acc & valid_input}, 64'd0);
      check("out_valid_in_idle", {63'd0, out_valid & ready}, 64'd0);
      if (valid_input) begin
        check("addr_w_row_major", 64'(prev_aw), 64'(int'(prev_row) * cur_n + int'(prev_ax)));
        acc = acc + 32'(wmem[prev_aw[7:0]]) * 32'(xmem[prev_ax]);
        aw_log.push_back(prev_aw);
        ax_log.push_back(prev_ax);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("result_kind", {63'd0, e[40]}, 64'd0);
          check("result_row", 64'(row_idx), 64'(e[39:32]));
          check("result_value", 64'(acc), 64'(e[31:0]));
        end
      end
      if (clear_acc) acc = '0;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_kind", {63'd0, e[40]}, 64'd1);
        end
      end
      prev_aw  = addr_w;
      prev_ax  = addr_x;
      prev_row = row_idx;
    end
  end

  // driver tasks
  task automatic wait_ready(input int budget);
    int k = 0;
    while (ready !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) check("ready_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_product(input int m, input int n);
    int sum;
    logic [EW-1:0] ent;
    wait_ready(500);
    for (int i = 0; i < 256; i++) begin
      wmem[i] = 8'($urandom_range(0, 255));
      xmem[i] = 8'($urandom_range(0, 255));
    end
    if (m > 0 && n > 0) begin
      for (int r = 0; r < m; r++) begin
        sum = 0;
        for (int c = 0; c < n; c++) sum += int'(wmem[r * n + c]) * int'(xmem[c]);
        ent = {1'b0, r[7:0], sum[31:0]};
        exp_q.push_back(ent);
      end
    end
    ent = {1'b1, 8'd0, 32'd0};
    exp_q.push_back(ent);
    cur_n    = n;
    num_rows = m[RW-1:0];
    num_cols = n[CW-1:0];
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (!(exp_q.size() == 0 && ready === 1'b1) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) check("drain_timeout", 64'd1, 64'd0);
    @(negedge clk);
  endtask

  task automatic check_latency(input int n);
    int k = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("result_latency", 64'(k), 64'(n + 2));
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    cur_n = 1;
    or_mode = 0;
    out_ready = 1'b1;
    start = 1'b0;
    num_rows = '0;
    num_cols = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_addr_w", 64'(addr_w), 64'd0);
    check("rst_addr_x", 64'(addr_x), 64'd0);
    check("rst_outputs", {58'd0, valid_input, clear_acc, out_valid, done, 2'd0}, 64'd0);
    check("rst_row_idx", 64'(row_idx), 64'd0);
    reset = 1'b0;

    // 2x3, consumer always ready: exact address stream and latency
    aw_log.delete();
    ax_log.delete();
    run_product(2, 3);
    check_latency(3);
    wait_drain(200);
    check("addr_count", 64'(aw_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < aw_log.size(); i++) begin
      check("addr_w_seq", 64'(aw_log[i]), 64'(i));
      check("addr_x_seq", 64'(ax_log[i]), 64'(i % 3));
    end

    // 1x4 with the consumer stalled for 10 cycles
    or_mode = 2;
    run_product(1, 4);
    check_latency(4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_row_idx", 64'(row_idx), 64'd0);
      check("stall_addr_w", 64'(addr_w), 64'd3);
      check("stall_valid_input", 64'(valid_input), 64'd0);
      check("stall_done", 64'(done), 64'd0);
    end
    or_mode = 0;
    wait_drain(200);

    // zero rows: done only, one cycle after start
    run_product(0, 5);
    @(negedge clk);
    check("zero_done", 64'(done), 64'd1);
    check("zero_ready", 64'(ready), 64'd1);
    check("zero_no_activity", {62'd0, valid_input, out_valid}, 64'd0);
    @(negedge clk);
    check("zero_done_pulse", 64'(done), 64'd0);
    wait_drain(50);

    // start with a different row count during ISSUE is ignored
    run_product(3, 4);
    num_rows = 8'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain(300);

    // asynchronous reset during DRAIN, between edges
    run_product(1, 3);
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 64'(ready), 64'd1);
    check("mid_rst_addr", {32'd0, addr_w, 8'd0, addr_x}, 64'd0);
    check("mid_rst_outputs", {58'd0, valid_input, clear_acc, out_valid, done, 2'd0}, 64'd0);
    check("mid_rst_row_idx", 64'(row_idx), 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run_product(2, 2);
    check_latency(2);
    wait_drain(200);

    // randomized products with random backpressure
    or_mode = 1;
    for (int t = 0; t < 25; t++) begin
      int m;
      int n;
      m = $urandom_range(1, 6);
      n = $urandom_range(1, 6);
      if ($urandom_range(0, 9) == 0) m = 0;
      if ($urandom_range(0, 9) == 0) n = 0;
      run_product(m, n);
      wait_drain(600);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 The block SHALL have parameters:
- RW, default 8, row-count/index width.
- CW, default 8, column-count/index width.
- AW, default 16, matrix address width; AW >= RW+CW.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a matrix-vector product; honoured only while ready=1.
- num_rows  in  RW  M, rows of matrix; sampled on accepted start.
- num_cols  in  CW  N, columns and vector length; sampled on accepted start.
- ready  out  1  high only in IDLE.
- addr_w  out  AW  matrix memory read address, row-major: row*N+col.
- addr_x  out  CW  vector memory read address, equal to col.
- valid_input  out  1  MAC valid_input; data from the previous cycle's addresses is present.
- clear_acc  out  1  MAC accumulator clear.
- out_valid  out  1  MAC out holds the complete dot product of row row_idx.
- out_ready  in  1  consumer accepts the result.
- row_idx  out  RW  row whose result is being produced or presented.
- done  out  1  one-cycle pulse after the last row result is accepted.

Function
REQ-003 The block SHALL implement FSM states IDLE, ISSUE, DRAIN and OUT.
REQ-004 The block SHALL, in IDLE, drive ready=1 and, on start=1 with M>0 and N>0, latch M and N, zero row and col, assert clear_acc for that cycle, and move to ISSUE.
REQ-005 The block SHALL, on start=1 in IDLE with M=0 or N=0, stay in IDLE, emit no out_valid, and pulse done in the next cycle.
REQ-006 The block SHALL, in ISSUE, present addr_w=row*N+col and addr_x=col each cycle, and increment col until col=N-1; the cycle with col=N-1 is followed by DRAIN.
REQ-007 The block SHALL drive valid_input as a register of "state==ISSUE", so it is high exactly one cycle after each issued address pair (1-cycle memory read latency).
REQ-008 The block SHALL hold DRAIN for exactly 2 cycles so that the MAC product register and accumulator settle, then enter OUT.
REQ-009 Result latency SHALL be: first address at relative cycle 0 -> out_valid=1 at cycle N+2.
REQ-010 The block SHALL, in OUT, hold out_valid=1 and row_idx stable until out_ready=1; the handshake is out_valid && out_ready at a clock edge.
REQ-011 The block SHALL assert clear_acc during the handshake cycle.
REQ-012 After a handshake, if row<M-1 the block SHALL increment row, set col=0, and enter ISSUE; otherwise it SHALL enter IDLE and pulse done for one cycle.
REQ-013 addr_w SHALL be maintained by a running counter, incremented by 1 per issue and never reset between rows, so no multiplier is used; its value SHALL equal row*N+col at all times.
REQ-014 The block SHALL ignore start outside IDLE, and SHALL NOT change the latched M and N mid-operation.
REQ-015 In every state other than ISSUE, addr_w and addr_x SHALL hold their last value; valid_input=0 except for the cycle following ISSUE.
REQ-016 clear_acc SHALL never be asserted while valid_input=1.
REQ-017 out_valid SHALL never be asserted in IDLE, ISSUE or DRAIN.
REQ-018 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-019 On reset=1, regardless of clk, the block SHALL enter IDLE and set these outputs to 0: row, col, addr_w, addr_x, valid_input, clear_acc, out_valid, done, row_idx.
REQ-020 While in reset, the block SHALL drive ready=1.
REQ-021 Reset asserted mid-operation SHALL abort the product with no done pulse.
REQ-022 After reset deasserts, the first start SHALL be honoured on the first clock edge.

Verification
REQ-023 M=2, N=3, out_ready=1 -> addr_w sequence 0,1,2 then 3,4,5; addr_x 0,1,2 repeated; out_valid at cycle 5 after the first issue; done pulses once.
REQ-024 M=1, N=4, out_ready held 0 for 10 cycles -> out_valid and row_idx=0 remain stable; no new addresses issued; done only after out_ready rises.
REQ-025 start with M=0, N=5 -> no valid_input, no out_valid, done=1 exactly one cycle later, ready stays 1.
REQ-026 start pulsed during ISSUE with different num_rows -> ignored; address sequence matches the original M.
REQ-027 Async reset asserted mid-DRAIN, between clock edges -> all outputs 0 immediately; ready=1; no done; a new start afterwards runs normally.
REQ-028 With the MAC connected (INW=16), each result equals the reference dot product or its saturated value; clear_acc precedes every row.
